// File: rtl/dsp_stream_reader.sv
// Streams the CPU display window out as printable characters over a
// valid/ready byte interface, one FETCH per memory byte.
module dsp_stream_reader #(
    parameter logic [7:0] FIRST_ADDR     = 8'h80,
    parameter logic [7:0] LAST_ADDR      = 8'hFF,
    parameter int         BYTES_PER_LINE = 8,
    parameter bit         HEX_MODE       = 1'b0,
    parameter logic [7:0] NEWLINE_CHAR   = 8'h0A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    localparam int CW = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(BYTES_PER_LINE - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_CH0   = 3'd2;
    localparam logic [2:0] S_CH1   = 3'd3;
    localparam logic [2:0] S_SEP   = 3'd4;
    localparam logic [2:0] S_NL    = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [7:0]    ptr_q, ptr_d;
    logic [7:0]    byte_q, byte_d;
    logic [CW-1:0] col_q, col_d;
    logic          accept;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) hex_char = 8'h30 + {4'h0, nib};
        else             hex_char = 8'h37 + {4'h0, nib};
    endfunction

    // Output side depends only on registered state, never on out_ready.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        case (state_q)
            S_CH0: begin
                out_valid = 1'b1;
                if (HEX_MODE)
                    out_data = hex_char(byte_q[7:4]);
                else if (byte_q >= 8'h20 && byte_q <= 8'h7E)
                    out_data = byte_q;
                else
                    out_data = 8'h2E;
            end
            S_CH1: begin
                out_valid = 1'b1;
                out_data  = hex_char(byte_q[3:0]);
            end
            S_SEP: begin
                out_valid = 1'b1;
                out_data  = 8'h20;
            end
            S_NL: begin
                out_valid = 1'b1;
                out_data  = NEWLINE_CHAR;
            end
            default: ;
        endcase
    end

    assign accept  = out_valid & out_ready;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_FIN);
    assign rd_addr = ptr_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        col_d   = col_q;
        byte_d  = byte_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    ptr_d   = FIRST_ADDR;
                    col_d   = '0;
                end
            end
            S_FETCH: begin
                byte_d  = rd_data;
                state_d = S_CH0;
            end
            S_CH0: begin
                if (accept) state_d = HEX_MODE ? S_CH1 : S_SEP;
            end
            S_CH1: begin
                if (accept) state_d = S_SEP;
            end
            S_SEP: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = S_NL;
                    end else if (ptr_q == LAST_ADDR) begin
                        state_d = S_NL;
                    end else begin
                        col_d   = col_q + CW'(1);
                        ptr_d   = ptr_q + 8'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            // Compare before increment so LAST_ADDR=0xFF never wraps.
            S_NL: begin
                if (accept) begin
                    if (ptr_q == LAST_ADDR) begin
                        state_d = S_FIN;
                    end else begin
                        ptr_d   = ptr_q + 8'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= FIRST_ADDR;
            col_q   <= '0;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            col_q   <= col_d;
            byte_q  <= byte_d;
        end
    end

endmodule

// File: tb/tb_dsp_stream_reader.sv
// Bench for dsp_stream_reader: character, hex and short-window instances
// share one memory; streams are compared against a reference model.
module tb_dsp_stream_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic       st [3];
    logic [7:0] ra [3];
    logic [7:0] rd [3];
    logic [7:0] od [3];
    logic       ov [3];
    logic       bz [3];
    logic       dn [3];

    logic [7:0] mem [256];
    logic [7:0] strm  [3][512];
    logic [7:0] exp_s [3][512];
    int         n [3];
    int         elen [3];
    int         dcnt [3];
    int         dcyc [3];
    int         acyc [3];
    logic       bafter [3];
    logic       bfin [3];
    logic       hp [3];
    logic [7:0] hd [3];
    logic       dp [3];
    int         bviol;
    int         cyc;
    bit         rand_rdy;
    int         checks;
    int         errors;
    string      hs = "0123456789ABCDEF";

    typedef struct {
        logic [7:0] b;
        logic [7:0] chr;
        logic [7:0] h0;
        logic [7:0] h1;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    assign rd[0] = mem[ra[0]];
    assign rd[1] = mem[ra[1]];
    assign rd[2] = mem[ra[2]];

    dsp_stream_reader u_chr (
        .clk(clk), .rst(rst), .start(st[0]),
        .rd_addr(ra[0]), .rd_data(rd[0]),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(rdy),
        .busy(bz[0]), .done(dn[0])
    );

    dsp_stream_reader #(.HEX_MODE(1'b1)) u_hex (
        .clk(clk), .rst(rst), .start(st[1]),
        .rd_addr(ra[1]), .rd_data(rd[1]),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(rdy),
        .busy(bz[1]), .done(dn[1])
    );

    dsp_stream_reader #(.FIRST_ADDR(8'hFC), .LAST_ADDR(8'hFF)) u_bnd (
        .clk(clk), .rst(rst), .start(st[2]),
        .rd_addr(ra[2]), .rd_data(rd[2]),
        .out_data(od[2]), .out_valid(ov[2]), .out_ready(rdy),
        .busy(bz[2]), .done(dn[2])
    );

    always begin
        @(posedge clk);
        #1;
        rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                if (hp[k]) begin
                    checks++;
                    if (!ov[k] || od[k] != hd[k]) begin
                        errors++;
                        $display("FAIL hold%0d got v=%0b d=%h want v=1 d=%h",
                                 k, ov[k], od[k], hd[k]);
                    end
                end
                hp[k] = ov[k] && !rdy;
                hd[k] = od[k];
                if (ov[k] && rdy) begin
                    if (n[k] < 512) strm[k][n[k]] = od[k];
                    n[k]++;
                    acyc[k] = cyc;
                end
                if (dp[k]) bafter[k] = bz[k];
                dp[k] = dn[k];
                if (dn[k]) begin
                    dcnt[k]++;
                    dcyc[k] = cyc;
                    bfin[k] = bz[k];
                end
                if (k == 2 && bz[2] && ra[2] < 8'hFC) bviol++;
            end else begin
                hp[k] = 1'b0;
                dp[k] = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic clr();
        for (int k = 0; k < 3; k++) begin
            n[k] = 0;
            dcnt[k] = 0;
            dcyc[k] = -1;
            acyc[k] = -1;
        end
    endtask

    task automatic model(input int k, input int first, input int last,
                         input int bpl, input bit hex);
        int p;
        int col;
        logic [7:0] b;
        p = 0;
        col = 0;
        for (int a = first; a <= last; a++) begin
            b = mem[a];
            if (hex) begin
                exp_s[k][p] = hs[b[7:4]];
                exp_s[k][p+1] = hs[b[3:0]];
                p += 2;
            end else begin
                exp_s[k][p] = (b >= 8'h20 && b <= 8'h7E) ? b : 8'h2E;
                p += 1;
            end
            exp_s[k][p] = 8'h20;
            p += 1;
            col++;
            if (col == bpl || a == last) begin
                exp_s[k][p] = 8'h0A;
                p += 1;
                col = 0;
            end
        end
        elen[k] = p;
    endtask

    task automatic model_all();
        model(0, 'h80, 'hFF, 8, 1'b0);
        model(1, 'h80, 'hFF, 8, 1'b1);
        model(2, 'hFC, 'hFF, 8, 1'b0);
    endtask

    task automatic cmp(input int k, input string nm);
        int bad;
        bad = -1;
        chk({nm, "_len"}, n[k], elen[k]);
        for (int i = 0; i < n[k] && i < elen[k] && i < 512; i++)
            if (bad < 0 && strm[k][i] != exp_s[k][i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_data idx %0d got %h want %h",
                     nm, bad, strm[k][bad], exp_s[k][bad]);
        end
    endtask

    task automatic pulse(input bit a, input bit b, input bit c);
        @(posedge clk);
        #1;
        st[0] = a;
        st[1] = b;
        st[2] = c;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        st[1] = 1'b0;
        st[2] = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (!bz[0] && !bz[1] && !bz[2]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout got busy want idle", nm);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_all(input string nm);
        clr();
        model_all();
        pulse(1'b1, 1'b1, 1'b1);
        wait_idle(nm);
        cmp(0, {nm, "_chr"});
        cmp(1, {nm, "_hex"});
        cmp(2, {nm, "_bnd"});
    endtask

    initial begin
        string l1;
        int bad;
        int nl;
        bit ok;
        checks = 0;
        errors = 0;
        bviol = 0;
        cyc = 0;
        rand_rdy = 1'b0;
        rdy = 1'b1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0;
            hp[k] = 1'b0;
            dp[k] = 1'b0;
        end
        clr();
        tbl[0] = '{8'hA5, 8'h2E, 8'h41, 8'h35};
        tbl[1] = '{8'h07, 8'h2E, 8'h30, 8'h37};
        tbl[2] = '{8'h48, 8'h48, 8'h34, 8'h38};
        tbl[3] = '{8'h20, 8'h20, 8'h32, 8'h30};
        tbl[4] = '{8'h7E, 8'h7E, 8'h37, 8'h45};
        tbl[5] = '{8'h7F, 8'h2E, 8'h37, 8'h46};
        tbl[6] = '{8'h1F, 8'h2E, 8'h31, 8'h46};
        tbl[7] = '{8'hFF, 8'h2E, 8'h46, 8'h46};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", int'(ov[0]), 0);
        chk("rst_busy", int'(bz[0]), 0);
        chk("rst_done", int'(dn[0]), 0);
        chk("rst_data", int'(od[0]), 0);
        chk("rst_addr", int'(ra[0]), 'h80);
        chk("rst_addr_bnd", int'(ra[2]), 'hFC);

        // "Hello" followed by zeros
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem['h80] = "H";
        mem['h81] = "e";
        mem['h82] = "l";
        mem['h83] = "l";
        mem['h84] = "o";
        run_all("hello");
        chk("hello_count", n[0], 272);
        chk("hex_count", n[1], 400);
        chk("bnd_count", n[2], 9);
        l1 = "H e l l o . . . ";
        bad = -1;
        for (int i = 0; i < 16; i++)
            if (bad < 0 && strm[0][i] != l1[i]) bad = i;
        chk("line1_first_bad", bad, -1);
        chk("line1_nl", int'(strm[0][16]), 'h0A);
        chk("done_cnt", dcnt[0], 1);
        chk("done_cyc", dcyc[0], acyc[0] + 1);
        chk("busy_in_fin", int'(bfin[0]), 1);
        chk("busy_fall", int'(bafter[0]), 0);
        chk("done_cnt_hex", dcnt[1], 1);
        chk("done_cnt_bnd", dcnt[2], 1);

        // Per-byte formatting table
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 8; i++) mem['h80 + i] = tbl[i].b;
        run_all("tbl");
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tbl_chr%0d", i), int'(strm[0][2*i]), int'(tbl[i].chr));
            chk($sformatf("tbl_h0_%0d", i), int'(strm[1][3*i]), int'(tbl[i].h0));
            chk($sformatf("tbl_h1_%0d", i), int'(strm[1][3*i+1]), int'(tbl[i].h1));
        end
        nl = 0;
        for (int i = 0; i < n[1] && i < 512; i++)
            if (strm[1][i] == 8'h0A) nl++;
        chk("hex_newlines", nl, 16);

        // Random contents under 50% backpressure
        for (int r = 0; r < 2; r++) begin
            for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
            rand_rdy = 1'b1;
            run_all($sformatf("bp%0d", r));
            rand_rdy = 1'b0;
        end
        chk("bnd_no_wrap", bviol, 0);

        // Starts while busy and during FIN are ignored
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        clr();
        model_all();
        pulse(1'b1, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        pulse(1'b1, 1'b0, 1'b0);
        repeat (300) @(posedge clk);
        #1;
        pulse(1'b1, 1'b0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (dn[0]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("fin_seen", int'(ok), 1);
        st[0] = 1'b1;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("ign_busy", int'(bz[0]), 0);
        chk("ign_done_cnt", dcnt[0], 1);
        cmp(0, "ign");

        // Reset after the 50th accepted character
        clr();
        rand_rdy = 1'b1;
        pulse(1'b1, 1'b1, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (n[0] >= 50) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst50_reached", int'(ok), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst50_valid", int'(ov[0]), 0);
        chk("rst50_busy", int'(bz[0]), 0);
        chk("rst50_busy_hex", int'(bz[1]), 0);
        chk("rst50_done", int'(dn[0]), 0);
        chk("rst50_no_done", dcnt[0], 0);
        rand_rdy = 1'b0;
        run_all("restart");
        chk("restart_count", n[0], 272);
        chk("restart_done", dcnt[0], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_stream_reader.md
Name: dsp_stream_reader

Overview:
- Display-side reader for the CPU's memory-mapped display window (default 0x80-0xFF).
- On a `start` pulse (driven by the DSP instruction decode), it walks the window through a combinational memory read port.
- It formats each byte as printable characters and streams them out over a valid/ready byte interface, toward a UART or console sink.
- It replaces the simulation-only dump with synthesizable hardware.

Parameters:
- FIRST_ADDR, 8'h80, first memory address scanned.
- LAST_ADDR, 8'hFF, last memory address scanned (inclusive; FIRST_ADDR <= LAST_ADDR).
- BYTES_PER_LINE, 8, data bytes emitted per line before a newline.
- HEX_MODE, 0, 0 = character mode, 1 = two uppercase hex digits per byte.
- NEWLINE_CHAR, 8'h0A, line terminator byte.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; honoured only in IDLE.
- rd_addr  output  8  memory read address (combinational read, data same cycle).
- rd_data  input  8  memory read data for rd_addr.
- out_data  output  8  character to sink.
- out_valid  output  1  out_data valid.
- out_ready  input  1  sink accepts when out_valid & out_ready at a rising edge.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final character is accepted.

Behaviour:
- Reset: state=IDLE, ptr=FIRST_ADDR, col=0, out_valid=0, out_data=0, busy=0, done=0; rd_addr=ptr.
- rd_addr is always ptr. Memory is read-only from this block; no write port.
- States:
  - IDLE: waits for start.
  - FETCH: latches rd_data into byte_r.
  - CH0: first character of the entry.
  - CH1: second hex digit; entered only when HEX_MODE=1.
  - SEP: 0x20 separator.
  - NL: NEWLINE_CHAR.
  - FIN: done pulse.
- IDLE: start=1 -> FETCH, ptr=FIRST_ADDR, col=0. Start asserted in any other state is ignored, not queued.
- FETCH: byte_r <= rd_data; go to CH0. This is 1 cycle, with out_valid=0.
- CH0: out_valid=1.
  - Character mode: out_data = byte_r if 0x20 <= byte_r <= 0x7E, else 0x2E ('.').
  - Hex mode: out_data = ASCII of byte_r[7:4] ('0'-'9', 'A'-'F').
  - On accept: go to CH1 if HEX_MODE, else SEP.
- CH1: out_data = ASCII of byte_r[3:0]; on accept go to SEP.
- SEP: out_data=0x20. On accept:
  - If col==BYTES_PER_LINE-1: col<=0 and go to NL.
  - Else if ptr==LAST_ADDR: go to NL (a partial final line is always terminated).
  - Else: col<=col+1, ptr<=ptr+1, go to FETCH.
- NL: out_data=NEWLINE_CHAR. On accept:
  - If ptr==LAST_ADDR: go to FIN.
  - Else: ptr<=ptr+1, go to FETCH.
- FIN: done=1 for exactly this cycle, out_valid=0; go to IDLE. busy stays 1 in FIN.
- Handshake:
  - While out_valid=1 and out_ready=0, out_data and state hold stable.
  - out_valid never drops without acceptance, except on rst.
  - No combinational path from out_ready to out_valid.
- ptr compare precedes increment; ptr never wraps past LAST_ADDR. LAST_ADDR=0xFF must not wrap to 0x00.
- Memory contents changing during a dump: each byte is sampled once, in its FETCH cycle.
- rst mid-dump: the next cycle shows IDLE with out_valid=0. No done pulse, and no partial character is re-sent.
- Throughput (out_ready held 1):
  - Character mode: 3 cycles/byte plus 1 cycle/line.
  - Hex mode: 4 cycles/byte plus 1 cycle/line.
- Output counts for the default window:
  - Character mode: 128*2 + 16 = 272 characters.
  - Hex mode: 128*3 + 16 = 400 characters.

Test Plan:
- Character dump: memory 0x80-0xFF = "Hello" then 0x00s, out_ready=1, pulse start.
  - Required: 272 characters; line 1 = "H e l l o . . . " then 0x0A.
  - Required: done pulses once, on the cycle after the final 0x0A is accepted; busy falls the following cycle.
- Hex mode: HEX_MODE=1, mem[0x80]=0xA5, mem[0x81]=0x07.
  - Required: stream begins "A5 07 "; 400 characters total; 16 newlines.
- Backpressure: random out_ready (50%).
  - Required: the stream is identical to the out_ready=1 run.
  - Required: out_data is stable whenever out_valid & !out_ready.
- Boundaries: FIRST_ADDR=0xFC, LAST_ADDR=0xFF, BYTES_PER_LINE=8.
  - Required: 4 entries + 1 newline (9 characters); no access to 0x00 after 0xFF.
- Start while busy, and start during FIN: ignored; exactly one dump and one done pulse.
- Reset at the 50th accepted character:
  - Required next cycle: out_valid=0, busy=0.
  - Required: a new start restarts at FIRST_ADDR and yields the full 272 characters.
